// File: rtl/axi_mem_pkg.sv
// Shared constants, FSM state types and burst helpers for the AXI4 burst memory slave.
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // AXI4 only allows wrapping bursts of 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus illegal-burst flag.
module axi_burst_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int NUMBYTES = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              burst_err
);

    localparam int SHIFT = $clog2(NUMBYTES);

    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              wrap_ok;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        incr_addr = addr + ADDR_W'(NUMBYTES);
        wrap_ok   = (burst == BURST_WRAP) && wrap_len_ok(len);
        wrap_mask = ((ADDR_W'(len[3:0]) + ADDR_W'(1)) << SHIFT) - ADDR_W'(1);
        burst_err = ((burst == BURST_WRAP) && !wrap_ok) || (burst == 2'b11);
        next_addr = incr_addr;

        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if (wrap_ok) begin
            // Upper bits stay on the wrap boundary, lower bits roll over inside it.
            next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst slave memory: independent write and read FSMs sharing one word array,
// with INCR/WRAP/FIXED bursts, byte strobes and SLVERR for out-of-range or malformed bursts.
module axi_burst_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,

    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,

    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,

    input  logic [ID_W-1:0]       ARID,
    input  logic [ADDR_W-1:0]     ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,

    output logic [ID_W-1:0]       RID,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int NUMBYTES = DATA_W / 8;
    localparam int SHIFT    = $clog2(NUMBYTES);
    localparam int IDX_W    = ADDR_W - SHIFT;
    localparam int MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // Holds the ready outputs low through reset and rises one cycle after release.
    logic live;

    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!ARESETn) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- write channel
    w_state_t          w_state, w_state_nxt;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic [1:0]        aw_burst;
    logic [7:0]        w_cnt;
    logic              w_err;

    logic [ADDR_W-1:0] w_next_addr;
    logic              w_burst_err;
    logic [IDX_W-1:0]  w_idx;
    logic              w_oob;
    logic              w_last_beat;
    logic              w_beat_err;
    logic              aw_hs;
    logic              w_hs;

    axi_burst_addr_gen #(
        .ADDR_W   (ADDR_W),
        .NUMBYTES (NUMBYTES)
    ) u_w_addr_gen (
        .addr      (aw_addr),
        .len       (aw_len),
        .burst     (aw_burst),
        .next_addr (w_next_addr),
        .burst_err (w_burst_err)
    );

    assign w_idx       = aw_addr[ADDR_W-1:SHIFT];
    assign w_oob       = {1'b0, w_idx} >= DEPTH_W;
    assign w_last_beat = (w_cnt == aw_len);
    assign w_beat_err  = w_oob || w_burst_err || (WLAST != w_last_beat);
    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;

    always_comb begin
        w_state_nxt = w_state;
        AWREADY     = 1'b0;
        WREADY      = 1'b0;
        BVALID      = 1'b0;
        case (w_state)
            W_IDLE: begin
                AWREADY = live;
                if (AWVALID && live) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                // Beat count, not WLAST, closes the burst.
                if (WVALID && w_last_beat) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state  <= W_IDLE;
            aw_id    <= '0;
            aw_addr  <= '0;
            aw_len   <= '0;
            aw_burst <= BURST_FIXED;
            w_cnt    <= '0;
            w_err    <= 1'b0;
            BID      <= '0;
            BRESP    <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                aw_id    <= AWID;
                aw_addr  <= AWADDR;
                aw_len   <= AWLEN;
                aw_burst <= AWBURST;
                w_cnt    <= '0;
                w_err    <= 1'b0;
            end
            if (w_hs) begin
                aw_addr <= w_next_addr;
                w_cnt   <= w_cnt + 8'd1;
                w_err   <= w_err || w_beat_err;
                if (w_last_beat) begin
                    BID   <= aw_id;
                    BRESP <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        // NOTE: the storage array has no reset; contents survive ARESETn and map onto plain RAM.
        if (w_hs && !w_oob && ARESETn) begin
            for (int b = 0; b < NUMBYTES; b++) begin
                if (WSTRB[b]) mem[w_idx[MEM_AW-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // ---------------------------------------------------------------- read channel
    r_state_t          r_state, r_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [1:0]        r_burst;
    logic [7:0]        r_beat;

    logic [ADDR_W-1:0] r_cur_addr;
    logic [7:0]        r_cur_len;
    logic [1:0]        r_cur_burst;
    logic [ADDR_W-1:0] r_next_addr;
    logic              r_burst_err;
    logic [IDX_W-1:0]  r_idx;
    logic              r_oob;
    logic              ar_hs;
    logic              r_hs;
    logic              r_load;

    // Beat 0 is fetched straight from ARADDR on the handshake; later beats from the held address.
    assign r_cur_addr  = (r_state == R_IDLE) ? ARADDR  : r_addr;
    assign r_cur_len   = (r_state == R_IDLE) ? ARLEN   : r_len;
    assign r_cur_burst = (r_state == R_IDLE) ? ARBURST : r_burst;

    axi_burst_addr_gen #(
        .ADDR_W   (ADDR_W),
        .NUMBYTES (NUMBYTES)
    ) u_r_addr_gen (
        .addr      (r_cur_addr),
        .len       (r_cur_len),
        .burst     (r_cur_burst),
        .next_addr (r_next_addr),
        .burst_err (r_burst_err)
    );

    assign r_idx  = r_cur_addr[ADDR_W-1:SHIFT];
    assign r_oob  = {1'b0, r_idx} >= DEPTH_W;
    assign ar_hs  = ARVALID && ARREADY;
    assign r_hs   = RVALID && RREADY;
    assign r_load = ar_hs || (r_hs && !RLAST);

    always_comb begin
        r_state_nxt = r_state;
        ARREADY     = 1'b0;
        RVALID      = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = live;
                if (ARVALID && live) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY && RLAST) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= BURST_FIXED;
            r_beat  <= '0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            RLAST   <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                RID     <= ARID;
                r_len   <= ARLEN;
                r_burst <= ARBURST;
                r_beat  <= '0;
                RLAST   <= (ARLEN == 8'd0);
            end else if (r_hs && !RLAST) begin
                r_beat <= r_beat + 8'd1;
                RLAST  <= ((r_beat + 8'd1) == r_len);
            end
            // A write to the same word on this edge is not yet visible: the read sees old data.
            if (r_load) begin
                r_addr <= r_next_addr;
                RDATA  <= r_oob ? '0 : mem[r_idx[MEM_AW-1:0]];
                RRESP  <= (r_oob || r_burst_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave: directed bursts push expected B/R responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_burst_mem_slave;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID;
    logic [11:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARID;
    logic [11:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    always #5 ACLK = ~ACLK;

    axi_burst_mem_slave #(
        .ID_W   (4),
        .ADDR_W (12),
        .DATA_W (32),
        .DEPTH  (512)
    ) dut (
        .ACLK    (ACLK),    .ARESETn (ARESETn),
        .AWID    (AWID),    .AWADDR  (AWADDR),  .AWLEN  (AWLEN),  .AWBURST (AWBURST),
        .AWVALID (AWVALID), .AWREADY (AWREADY),
        .WDATA   (WDATA),   .WSTRB   (WSTRB),   .WLAST  (WLAST),
        .WVALID  (WVALID),  .WREADY  (WREADY),
        .BID     (BID),     .BRESP   (BRESP),   .BVALID (BVALID), .BREADY  (BREADY),
        .ARID    (ARID),    .ARADDR  (ARADDR),  .ARLEN  (ARLEN),  .ARBURST (ARBURST),
        .ARVALID (ARVALID), .ARREADY (ARREADY),
        .RID     (RID),     .RDATA   (RDATA),   .RRESP  (RRESP),  .RLAST   (RLAST),
        .RVALID  (RVALID),  .RREADY  (RREADY)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t r_q[$];
    b_exp_t b_q[$];

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;
    int rr_mode     = 0;   // 0: RREADY high, 1: random, 2: held low

    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    logic [49:0] all_outs;
    assign all_outs = {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID,
                       RID, RDATA, RRESP, RLAST};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic sel_ready(input int which);
        case (which)
            0:       return AWREADY;
            1:       return WREADY;
            default: return ARREADY;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic wait_hs(input string name, input int which);
        int n;
        n = 0;
        @(negedge ACLK);
        while (!sel_ready(which)) begin
            n++;
            if (n > 64) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_timeout: ready still 0 after %0d cycles, expected 1", name, n);
                break;
            end
            @(negedge ACLK);
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_w(input int i, input logic [31:0] d, input logic [3:0] s);
        wd[i] = d;
        ws[i] = s;
    endtask

    task automatic expect_r(input logic [3:0] id, input logic [31:0] d,
                            input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        r_q.push_back(e);
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input int wlast_beat,
                               input logic [1:0] exp_resp);
        b_exp_t e;
        e.id = id; e.resp = exp_resp;
        b_q.push_back(e);
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        wait_hs("aw", 0);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == wlast_beat); WVALID = 1'b1;
            wait_hs("w", 1);
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        @(negedge ACLK);
        check("bvalid_latency", BVALID, 1);
        @(posedge ACLK);
        #1;
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                              input logic [1:0] burst);
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        wait_hs("ar", 2);
        ARVALID = 1'b0;
        @(negedge ACLK);
        check("rvalid_latency", RVALID, 1);
        @(posedge ACLK);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        if (r_q.size() != 0 || b_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d R and %0d B responses outstanding, expected 0",
                     r_q.size(), b_q.size());
            r_q.delete();
            b_q.delete();
        end
        @(posedge ACLK);
        #1;
    endtask

    // RREADY pattern generator.
    initial begin
        RREADY = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            case (rr_mode)
                0:       RREADY = 1'b1;
                1:       RREADY = 1'($urandom_range(0, 1));
                default: RREADY = 1'b0;
            endcase
        end
    end

    // Monitor: pops expectations on each handshake, checks stability while R is stalled.
    b_exp_t      mb;
    r_exp_t      mr;
    bit          r_stalled = 1'b0;
    logic [38:0] r_held;

    always @(negedge ACLK) begin
        if (!mon_en) begin
            r_stalled = 1'b0;
        end else begin
            if (BVALID && BREADY) begin
                if (b_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL b_unexpected: got BID=%h BRESP=%h, expected no response", BID, BRESP);
                end else begin
                    mb = b_q.pop_front();
                    check("bid", BID, mb.id);
                    check("bresp", BRESP, mb.resp);
                end
            end
            if (RVALID) begin
                if (r_stalled) check("r_hold", {RID, RDATA, RRESP, RLAST}, r_held);
                if (RREADY) begin
                    r_stalled = 1'b0;
                    if (r_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL r_unexpected: got RDATA=%h, expected no beat", RDATA);
                    end else begin
                        mr = r_q.pop_front();
                        check("rid", RID, mr.id);
                        check("rdata", RDATA, mr.data);
                        check("rresp", RRESP, mr.resp);
                        check("rlast", RLAST, mr.last);
                    end
                end else begin
                    r_stalled = 1'b1;
                    r_held    = {RID, RDATA, RRESP, RLAST};
                end
            end else begin
                r_stalled = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0;

        // Reset and release
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_outputs", all_outs, 0);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        check("awready_after_reset", AWREADY, 1);
        check("arready_after_reset", ARREADY, 1);
        @(posedge ACLK);
        #1;
        mon_en = 1'b1;

        // INCR write 0xA0..0xA3 then read back with ID 5
        for (int i = 0; i < 4; i++) set_w(i, 32'hA0 + 32'(i), 4'hF);
        write_burst(4'd3, 12'h010, 8'd3, INCR, 3, OKAY);
        for (int i = 0; i < 4; i++) expect_r(4'd5, 32'hA0 + 32'(i), OKAY, i == 3);
        read_burst(4'd5, 12'h010, 8'd3, INCR);
        drain();

        // WRAP read from 0x018: words 0x018, 0x01C, 0x010, 0x014
        expect_r(4'd6, 32'hA2, OKAY, 1'b0);
        expect_r(4'd6, 32'hA3, OKAY, 1'b0);
        expect_r(4'd6, 32'hA0, OKAY, 1'b0);
        expect_r(4'd6, 32'hA1, OKAY, 1'b1);
        read_burst(4'd6, 12'h018, 8'd3, WRAP);
        drain();

        // FIXED, illegal WRAP length, and reserved burst type
        expect_r(4'd7, 32'hA0, OKAY, 1'b0);
        expect_r(4'd7, 32'hA0, OKAY, 1'b1);
        read_burst(4'd7, 12'h010, 8'd1, FIXED);
        expect_r(4'd8, 32'hA0, SLVERR, 1'b0);
        expect_r(4'd8, 32'hA1, SLVERR, 1'b0);
        expect_r(4'd8, 32'hA2, SLVERR, 1'b1);
        read_burst(4'd8, 12'h010, 8'd2, WRAP);
        expect_r(4'd9, 32'hA1, SLVERR, 1'b1);
        read_burst(4'd9, 12'h014, 8'd0, 2'b11);
        drain();

        // WRAP write of two beats from 0x104 lands on 0x104 then 0x100
        set_w(0, 32'hC0, 4'hF);
        set_w(1, 32'hC1, 4'hF);
        write_burst(4'd4, 12'h104, 8'd1, WRAP, 1, OKAY);
        expect_r(4'd4, 32'hC1, OKAY, 1'b0);
        expect_r(4'd4, 32'hC0, OKAY, 1'b1);
        read_burst(4'd4, 12'h100, 8'd1, INCR);
        drain();

        // Partial strobe over an all-ones word
        set_w(0, 32'hFFFF_FFFF, 4'hF);
        write_burst(4'd1, 12'h040, 8'd0, INCR, 0, OKAY);
        set_w(0, 32'h1122_3344, 4'h5);
        write_burst(4'd1, 12'h040, 8'd0, INCR, 0, OKAY);
        expect_r(4'd2, 32'hFF22_FF44, OKAY, 1'b1);
        read_burst(4'd2, 12'h040, 8'd0, INCR);
        drain();

        // Out of range (index 1023 >= 512) must not alias onto word 511
        set_w(0, 32'h1234_5678, 4'hF);
        write_burst(4'd10, 12'h7FC, 8'd0, INCR, 0, OKAY);
        set_w(0, 32'hDEAD_BEEF, 4'hF);
        write_burst(4'd2, 12'hFFC, 8'd0, INCR, 0, SLVERR);
        expect_r(4'd11, 32'h0, SLVERR, 1'b1);
        read_burst(4'd11, 12'hFFC, 8'd0, INCR);
        expect_r(4'd12, 32'h1234_5678, OKAY, 1'b1);
        read_burst(4'd12, 12'h7FC, 8'd0, INCR);
        drain();

        // Early WLAST: all four beats still written, response is SLVERR
        for (int i = 0; i < 4; i++) set_w(i, 32'hB0 + 32'(i), 4'hF);
        write_burst(4'd13, 12'h080, 8'd3, INCR, 1, SLVERR);
        for (int i = 0; i < 4; i++) expect_r(4'd14, 32'hB0 + 32'(i), OKAY, i == 3);
        read_burst(4'd14, 12'h080, 8'd3, INCR);
        drain();

        // Random RREADY back-pressure; stalled beats must hold
        rr_mode = 1;
        for (int i = 0; i < 4; i++) expect_r(4'd15, 32'hA0 + 32'(i), OKAY, i == 3);
        read_burst(4'd15, 12'h010, 8'd3, INCR);
        for (int i = 0; i < 4; i++) expect_r(4'd1, 32'hB0 + 32'(i), OKAY, i == 3);
        read_burst(4'd1, 12'h080, 8'd3, INCR);
        drain();

        // Reset in the middle of both a read and a write burst
        rr_mode = 2;
        repeat (2) @(posedge ACLK);
        #1;
        mon_en  = 1'b0;
        ARID = 4'd3; ARADDR = 12'h010; ARLEN = 8'd7; ARBURST = INCR; ARVALID = 1'b1;
        wait_hs("ar", 2);
        ARVALID = 1'b0;
        AWID = 4'd3; AWADDR = 12'h0C0; AWLEN = 8'd3; AWBURST = INCR; AWVALID = 1'b1;
        wait_hs("aw", 0);
        AWVALID = 1'b0;
        WDATA = 32'h77; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
        wait_hs("w", 1);
        WVALID = 1'b0;
        @(negedge ACLK);
        check("midburst_rvalid", RVALID, 1);
        check("midburst_wready", WREADY, 1);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        check("reset_midburst_outputs", all_outs, 0);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        rr_mode = 0;
        @(posedge ACLK);
        @(negedge ACLK);
        check("awready_after_midreset", AWREADY, 1);
        check("arready_after_midreset", ARREADY, 1);
        @(posedge ACLK);
        #1;
        r_q.delete();
        b_q.delete();
        mon_en = 1'b1;

        // Both channels usable again; memory kept its contents
        set_w(0, 32'h55, 4'hF);
        write_burst(4'd6, 12'h0C0, 8'd0, INCR, 0, OKAY);
        expect_r(4'd7, 32'h55, OKAY, 1'b1);
        read_burst(4'd7, 12'h0C0, 8'd0, INCR);
        expect_r(4'd8, 32'hA0, OKAY, 1'b1);
        read_burst(4'd8, 12'h010, 8'd0, INCR);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_burst_mem_slave.md
# axi_burst_mem_slave

Synthesizable, parametrised AXI4 burst slave memory that replaces the fixed single-beat AXI-lite dummy memory inside the emulation dut_wrapper. It accepts INCR, WRAP and FIXED bursts with IDs, byte strobes and full B/R response channels. The AXI master driver running on the server exercises it over the forced AXI port set. Read and write channels run independently against one shared word array.

## Interface
Parameters:
- ID_W, 4, width of AWID/ARID/BID/RID
- ADDR_W, 12, byte-address width
- DATA_W, 32, data width; NUMBYTES = DATA_W/8
- DEPTH, 1024, memory depth in words

Ports:
- ACLK  in  1  sole clock; reset is synchronous and active-low
- ARESETn  in  1  synchronous active-low reset
- AWID / AWADDR / AWLEN / AWBURST  in  ID_W / ADDR_W / 8 / 2  write address
- AWVALID  in  1;  AWREADY  out  1
- WDATA / WSTRB / WLAST  in  DATA_W / NUMBYTES / 1  write data
- WVALID  in  1;  WREADY  out  1
- BID / BRESP  out  ID_W / 2;  BVALID  out  1;  BREADY  in  1
- ARID / ARADDR / ARLEN / ARBURST  in  ID_W / ADDR_W / 8 / 2  read address
- ARVALID  in  1;  ARREADY  out  1
- RID / RDATA / RRESP / RLAST  out  ID_W / DATA_W / 2 / 1;  RVALID  out  1;  RREADY  in  1

## Operation
- Reset: all outputs 0. Memory contents are not cleared. A burst in flight when ARESETn falls is abandoned.
- Transfers are always full width. AxSIZE is not present. Address bits [log2(NUMBYTES)-1:0] are ignored.
- Word index = addr >> log2(NUMBYTES).
- Out of range: index >= DEPTH. A write to such a beat is suppressed and forces BRESP=SLVERR. A read of such a beat returns RDATA=0 with RRESP=SLVERR.
- Next address per burst type:
  - FIXED: unchanged.
  - INCR: +NUMBYTES, modulo 2^ADDR_W.
  - WRAP: wraps within a boundary of (LEN+1)*NUMBYTES bytes. A WRAP burst whose LEN is not 1, 3, 7 or 15 is treated as INCR and responds SLVERR.
  - Burst type 2'b11: treated as INCR with SLVERR.
- Write FSM: W_IDLE (AWREADY=1) → W_DATA (WREADY=1) → W_RESP (BVALID=1) → W_IDLE.
  - On the AW handshake, latch ID, address, LEN and type.
  - Each W handshake writes the bytes whose WSTRB bit is set.
  - The burst ends after LEN+1 beats. WLAST does not end it.
  - If WLAST is not asserted on exactly the last beat, BRESP=SLVERR.
- Read FSM: R_IDLE (ARREADY=1) → R_DATA (RVALID=1) → R_IDLE.
  - RLAST is 1 on beat LEN.
  - Data and RRESP are registered per beat.
- Same cycle, same word, R-beat load and W beat: the read returns the old data.
- Write and read FSMs operate concurrently.

## Timing
- AWREADY and ARREADY rise in the first cycle after ARESETn goes high.
- AW handshake at cycle t → WREADY=1 from t+1.
- Last W handshake at cycle u → BVALID=1 at u+1, held with stable BID/BRESP until BREADY. AWREADY=1 the cycle after the B handshake.
- AR handshake at t → RVALID=1 with beat 0 at t+1.
- While RREADY=1, one beat per cycle with no bubbles. RID/RDATA/RRESP/RLAST hold stable while RVALID=1 and RREADY=0.
- ARREADY=1 the cycle after the last R handshake.
- Minimum single-beat write: 3 cycles. A read of LEN+1 beats takes LEN+2 cycles.

## Structure
- Package axi_mem_pkg holds:
  - BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - FSM state enums
- Sub-module axi_burst_addr_gen (combinational next-address and wrap-mask logic) is instantiated once per channel.

## Test plan
- Reset release: all outputs 0 during reset. AWREADY=ARREADY=1 one cycle after release.
- INCR write, AWADDR=0x010, LEN=3, data 0xA0..0xA3, WSTRB=0xF → BRESP=OKAY. Then INCR read of the same burst → RDATA 0xA0..0xA3, RLAST on beat 3, RID echoes ARID=5.
- WRAP read, ARADDR=0x018, LEN=3 → addresses 0x018, 0x01C, 0x010, 0x014.
- Partial strobe: write 0x11223344 with WSTRB=0x5 over 0xFFFFFFFF → readback 0xFF22FF44.
- Out-of-range write to 0xFFC with DEPTH=512 → BRESP=SLVERR and memory unchanged. Read of the same address → RDATA=0, RRESP=SLVERR.
- Stress cases:
  - RREADY toggled randomly → R outputs stable while stalled.
  - Early WLAST on beat 1 of LEN=3 → 4 beats accepted, BRESP=SLVERR.
  - ARESETn low mid-burst → outputs 0 next cycle.
